seq_mult_alu: RTL and testbench

// Multi-cycle 16x16 unsigned shift-add multiplier for the ALU datapath.

---
 rtl/seq_mult_alu_pkg.sv | 15 +
 rtl/seq_mult_alu_adder.sv | 23 ++
 rtl/seq_mult_alu.sv | 103 ++++++++++
 tb/tb_seq_mult_alu.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_alu_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package seq_mult_alu_pkg;

  // Operand width is tied to the 16-bit ripple adder; no other value works.
  localparam int WIDTH = 16;
  // Iteration counter width; must be able to hold WIDTH.
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_alu_adder.sv
// 16-bit ripple-carry adder shared with the ALU datapath (no carry-out port).
module adder_alu
  import seq_mult_alu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] out
);

  logic carry;

  // Ripple the carry bit by bit from the LSB.
  always_comb begin
    out   = '0;
    carry = c_in;
    for (int i = 0; i < WIDTH; i++) begin
      out[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/seq_mult_alu.sv
// Multi-cycle 16x16 unsigned shift-add multiplier with start/busy/done handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; operands captured on an accepted start
// RUN     | one shift-add iteration per cycle, 16 iterations total
// DONE    | one-cycle done pulse, product valid; returns to IDLE
module seq_mult_alu
  import seq_mult_alu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   add;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               last_iter;

  assign add       = acc_lo[0] ? mcand : '0;
  assign last_iter = (count == CNT_W'(WIDTH - 1));

  adder_alu u_adder (
    .a    (acc_hi),
    .b    (add),
    .c_in (1'b0),
    .out  (sum)
  );

  // The shared adder has no carry-out, so rebuild it from the operand MSBs and sum MSB.
  assign cout = (acc_hi[WIDTH-1] & add[WIDTH-1]) |
                ((acc_hi[WIDTH-1] ^ add[WIDTH-1]) & ~sum[WIDTH-1]);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: if (start)     next_state = ST_RUN;
      ST_RUN:  if (last_iter) next_state = ST_DONE;
      ST_DONE:                next_state = ST_IDLE;
      default:                next_state = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register (glitch-free, never both high).
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, shift-add iteration, counter and product register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      product <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= a;
            acc_lo <= b;
            acc_hi <= '0;
            count  <= '0;
          end
        end
        ST_RUN: begin
          acc_hi <= {cout, sum[WIDTH-1:1]};
          acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
          count  <= count + CNT_W'(1);
          if (last_iter) product <= {cout, sum, acc_lo[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_alu.sv
// Self-checking bench for seq_mult_alu: directed corner cases plus random operands.
module tb_seq_mult_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int          tests  = 0;
  int          failed = 0;
  logic [31:0] model_prod;

  seq_mult_alu dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one multiply and follow it to completion. inject_at > 0 pulses a
  // competing start (7*7) on that RUN cycle, which must be ignored.
  task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b,
                        input int inject_at, input string tag);
    int          busy_cycles = 0;
    int          edges       = 0;
    bit          seen        = 0;
    bit          overlap     = 0;
    bit          held_ok     = 1;
    logic [31:0] exp;
    exp   = 32'(op_a) * 32'(op_b);
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    step();
    edges = 1;
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    while (edges < 40 && !seen) begin
      if (busy && done) overlap = 1;
      if (done) begin
        seen = 1;
      end else begin
        if (busy) begin
          busy_cycles++;
          if (product !== model_prod) held_ok = 0;
        end
        if (busy && busy_cycles == inject_at) begin
          start = 1'b1;
          a     = 16'd7;
          b     = 16'd7;
        end else begin
          start = 1'b0;
        end
        step();
        edges++;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(edges), 32'd17);
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd16);
    check({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
    check({tag, "_product_held"}, 32'(held_ok), 32'd1);
    check({tag, "_product"}, product, exp);
    model_prod = exp;
    step();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
    check({tag, "_product_kept"}, product, exp);
  endtask

  initial begin
    int npulse;
    int first_pulse;
    int second_pulse;
    bit drained;

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", product, 32'd0);
    reset      = 1'b0;
    model_prod = 32'd0;
    step();

    run_op(16'd3, 16'd5, 0, "mul_3x5");
    run_op(16'hFFFF, 16'hFFFF, 0, "mul_ffff");
    run_op(16'd0, 16'h1234, 0, "mul_zero_a");
    run_op(16'h1234, 16'd0, 0, "mul_zero_b");
    run_op(16'd3, 16'd5, 5, "mul_ignore_start");

    // Abort in the middle of a run.
    a     = 16'h00FF;
    b     = 16'h0100;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", product, 32'd0);
    reset      = 1'b0;
    model_prod = 32'd0;
    step();
    check("abort_stays_idle", 32'(busy), 32'd0);
    run_op(16'd2, 16'd2, 0, "mul_after_abort");

    // Start held high: back-to-back operations.
    npulse       = 0;
    first_pulse  = -1;
    second_pulse = -1;
    a            = 16'h8000;
    b            = 16'd2;
    start        = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) begin
        npulse++;
        if (npulse == 1) first_pulse = i;
        if (npulse == 2) second_pulse = i;
        check("b2b_product", product, 32'h0001_0000);
      end
    end
    start = 1'b0;
    check("b2b_pulses", 32'(npulse), 32'd2);
    check("b2b_spacing", 32'(second_pulse - first_pulse), 32'd18);
    drained = 0;
    for (int i = 0; i < 40 && !drained; i++) begin
      if (done) drained = 1;
      step();
    end
    check("b2b_drain", 32'(drained), 32'd1);
    model_prod = 32'h0001_0000;

    // Random operands against the arithmetic reference.
    for (int k = 0; k < 8; k++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k == 0) ra[15] = 1'b1;
      run_op(ra, rb, 0, $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
